// File: rtl/branch_unit.sv
// Resolves jal/jalr/conditional branches, flags mispredicts, trains a 2-bit bimodal table.
// Latency 1 through a one-entry output register; in_ready drops while a result is held unaccepted.
module branch_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_branch,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_next_pc,
    output logic [XLEN-1:0] out_link,
    output logic            out_mispredict,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
);
    localparam int IDX = $clog2(BHT_DEPTH);

    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_jalr_tgt;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_pred_pc;
    logic            w_eq;
    logic            w_lt;
    logic            w_taken;
    logic            w_mispredict;
    logic            w_accept;
    logic            w_is_br;
    logic [IDX-1:0]  w_upd_idx;
    logic [IDX-1:0]  w_look_idx;
    logic            w_unused;

    logic [1:0]      r_bht [BHT_DEPTH];
    logic            r_out_valid;
    logic            r_out_taken;
    logic [XLEN-1:0] r_out_next_pc;
    logic [XLEN-1:0] r_out_link;
    logic            r_out_mispredict;
    logic [31:0]     r_perf_br;
    logic [31:0]     r_perf_mis;

    assign w_pc4      = in_pc + XLEN'(4);
    assign w_br_tgt   = in_pc + in_imm;
    assign w_jalr_tgt = (in_rs1 + in_imm) & ~XLEN'(1);
    assign w_eq       = (in_rs1 == in_rs2);
    assign w_lt       = in_unsigned ? (in_rs1 < in_rs2) : ($signed(in_rs1) < $signed(in_rs2));

    always_comb begin
        w_taken   = 1'b0;
        w_next_pc = w_pc4;
        case (in_branch)
            3'b001: begin
                w_taken   = 1'b1;
                w_next_pc = w_br_tgt;
            end
            3'b010: begin
                w_taken   = 1'b1;
                w_next_pc = w_jalr_tgt;
            end
            3'b100:  w_taken = w_eq;
            3'b101:  w_taken = !w_eq;
            3'b110:  w_taken = w_lt;
            3'b111:  w_taken = !w_lt;
            default: w_taken = 1'b0;
        endcase
        if (in_branch[2] && w_taken) begin
            w_next_pc = w_br_tgt;
        end
    end

    // Mispredict is judged on the full next PC, so a "taken" guess for a non-branch also counts.
    assign w_pred_pc    = in_pred_taken ? in_pred_target : w_pc4;
    assign w_mispredict = (w_pred_pc != w_next_pc);
    assign w_is_br      = (in_branch != 3'b000) && (in_branch != 3'b011);

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_upd_idx  = in_pc[IDX+1:2];
    assign w_look_idx = lookup_pc[IDX+1:2];
    assign w_unused   = ^{lookup_pc[1:0], lookup_pc[XLEN-1:IDX+2]};

    assign lookup_taken = r_bht[w_look_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_accept && in_branch[2]) begin
            if (w_taken && (r_bht[w_upd_idx] != 2'b11)) begin
                r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'd1;
            end else if (!w_taken && (r_bht[w_upd_idx] != 2'b00)) begin
                r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid      <= 1'b0;
            r_out_taken      <= 1'b0;
            r_out_next_pc    <= '0;
            r_out_link       <= '0;
            r_out_mispredict <= 1'b0;
            r_perf_br        <= '0;
            r_perf_mis       <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid      <= 1'b1;
                r_out_taken      <= w_taken;
                r_out_next_pc    <= w_next_pc;
                r_out_link       <= w_pc4;
                r_out_mispredict <= w_mispredict;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && w_is_br && (r_perf_br != 32'hFFFF_FFFF)) begin
                r_perf_br <= r_perf_br + 32'd1;
            end
            if (w_accept && w_mispredict && (r_perf_mis != 32'hFFFF_FFFF)) begin
                r_perf_mis <= r_perf_mis + 32'd1;
            end
        end
    end

    assign out_valid        = r_out_valid;
    assign out_taken        = r_out_taken;
    assign out_next_pc      = r_out_next_pc;
    assign out_link         = r_out_link;
    assign out_mispredict   = r_out_mispredict;
    assign perf_branches    = r_perf_br;
    assign perf_mispredicts = r_perf_mis;
endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_branch = '0;
    logic        in_unsigned = 1'b0;
    logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
    logic        in_pred_taken = 1'b0;
    logic [31:0] in_pred_target = '0;
    logic        out_valid, out_ready = 1'b1, out_taken, out_mispredict;
    logic [31:0] out_next_pc, out_link;
    logic [31:0] lookup_pc = '0;
    logic        lookup_taken;
    logic [31:0] perf_branches, perf_mispredicts;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    int          m_bht [64];
    longint      m_br, m_mis;
    logic        exp_taken, exp_mis;
    logic [31:0] exp_npc, exp_link;

    branch_unit #(.XLEN(32), .BHT_DEPTH(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_branch(in_branch), .in_unsigned(in_unsigned), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_next_pc(out_next_pc), .out_link(out_link), .out_mispredict(out_mispredict),
        .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    function automatic longint sval(input logic [31:0] v);
        return v[31] ? longint'(v) - 64'sh1_0000_0000 : longint'(v);
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic model_accept(input logic [2:0] br, input logic uns,
                                input logic [31:0] pc, rs1, rs2, imm,
                                input logic pt, input logic [31:0] ptgt);
        logic [31:0] pc4, tgt, pred;
        logic        tk;
        int          ix;
        pc4 = pc + 32'd4;
        tgt = pc + imm;
        tk  = 1'b0;
        case (br)
            3'd1: tk = 1'b1;
            3'd2: begin tk = 1'b1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
            3'd4: tk = (rs1 == rs2);
            3'd5: tk = (rs1 != rs2);
            3'd6: tk = uns ? (rs1 < rs2) : (sval(rs1) < sval(rs2));
            3'd7: tk = uns ? (rs1 >= rs2) : (sval(rs1) >= sval(rs2));
            default: tk = 1'b0;
        endcase
        exp_taken = tk;
        exp_npc   = tk ? tgt : pc4;
        exp_link  = pc4;
        pred      = pt ? ptgt : pc4;
        exp_mis   = (pred != exp_npc);
        if (br != 3'd0 && br != 3'd3 && m_br < 64'hFFFF_FFFF) m_br++;
        if (exp_mis && m_mis < 64'hFFFF_FFFF) m_mis++;
        if (br >= 3'd4) begin
            ix = idx_of(pc);
            m_bht[ix] = tk ? ((m_bht[ix] == 3) ? 3 : m_bht[ix] + 1)
                           : ((m_bht[ix] == 0) ? 0 : m_bht[ix] - 1);
        end
    endtask

    // Presents one request, waits (bounded) for acceptance, updates the model at the accepting edge.
    task automatic do_req(input logic [2:0] br, input logic uns, input logic [31:0] pc, rs1, rs2, imm,
                          input logic pt, input logic [31:0] ptgt);
        int waited = 0;
        in_valid = 1'b1; in_branch = br; in_unsigned = uns; in_pc = pc;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
        #1;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL req_accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(br, uns, pc, rs1, rs2, imm, pt, ptgt);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_branch = 3'd4; in_pc = 32'h8000_0040; in_rs1 = 7; in_rs2 = 7;
        in_imm = 32'h20; in_pred_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0; rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL reset_out_taken: got %0b want 0", out_taken); end
        n_cmp++; if (out_next_pc !== 32'h0) begin n_fail++; $display("FAIL reset_next_pc: got %h want 0", out_next_pc); end
        n_cmp++; if (out_link !== 32'h0) begin n_fail++; $display("FAIL reset_link: got %h want 0", out_link); end
        n_cmp++; if (out_mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict: got %0b want 0", out_mispredict); end
        n_cmp++; if (perf_branches !== 32'h0) begin n_fail++; $display("FAIL reset_perf_br: got %0d want 0", perf_branches); end
        n_cmp++; if (perf_mispredicts !== 32'h0) begin n_fail++; $display("FAIL reset_perf_mis: got %0d want 0", perf_mispredicts); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        for (int i = 0; i < 64; i++) begin
            lookup_pc = 32'(i) << 2;
            #0.1;
            n_cmp++;
            if (lookup_taken !== 1'b0) begin n_fail++; $display("FAIL reset_bht[%0d]: got %0b want 0", i, lookup_taken); end
        end
    endtask

    task automatic test_beq();
        do_req(3'd4, 1'b0, 32'h8000_0000, 32'd5, 32'd5, 32'h10, 1'b0, 32'h0);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL beq_valid: got %0b want 1", out_valid); end
        n_cmp++; if (out_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %0b want 1", out_taken); end
        n_cmp++; if (out_next_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL beq_next_pc: got %h want 80000010", out_next_pc); end
        n_cmp++; if (out_mispredict !== 1'b1) begin n_fail++; $display("FAIL beq_mispredict: got %0b want 1", out_mispredict); end
        n_cmp++; if (perf_mispredicts !== 32'd1) begin n_fail++; $display("FAIL beq_perf_mis: got %0d want 1", perf_mispredicts); end
        n_cmp++; if (perf_branches !== 32'd1) begin n_fail++; $display("FAIL beq_perf_br: got %0d want 1", perf_branches); end
    endtask

    task automatic test_blt();
        do_req(3'd6, 1'b0, 32'h8000_0200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0);
        n_cmp++; if (out_taken !== 1'b1) begin n_fail++; $display("FAIL blt_signed_taken: got %0b want 1", out_taken); end
        n_cmp++; if (out_next_pc !== 32'h8000_0240) begin n_fail++; $display("FAIL blt_signed_pc: got %h want 80000240", out_next_pc); end
        do_req(3'd6, 1'b1, 32'h8000_0200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0);
        n_cmp++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL bltu_taken: got %0b want 0", out_taken); end
        n_cmp++; if (out_next_pc !== 32'h8000_0204) begin n_fail++; $display("FAIL bltu_pc: got %h want 80000204", out_next_pc); end
        n_cmp++; if (out_mispredict !== 1'b0) begin n_fail++; $display("FAIL bltu_mispredict: got %0b want 0", out_mispredict); end
    endtask

    task automatic test_jalr();
        do_req(3'd2, 1'b0, 32'h0000_1000, 32'h8000_0003, 32'h0, 32'h0, 1'b1, 32'h8000_0002);
        n_cmp++; if (out_next_pc !== 32'h8000_0002) begin n_fail++; $display("FAIL jalr_pc: got %h want 80000002", out_next_pc); end
        n_cmp++; if (out_link !== 32'h0000_1004) begin n_fail++; $display("FAIL jalr_link: got %h want 00001004", out_link); end
        n_cmp++; if (out_mispredict !== 1'b0) begin n_fail++; $display("FAIL jalr_mispredict: got %0b want 0", out_mispredict); end
        n_cmp++; if (perf_branches !== 32'(m_br)) begin n_fail++; $display("FAIL jalr_perf_br: got %0d want %0d", perf_branches, m_br); end
    endtask

    task automatic test_bht();
        logic want [6];
        want = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        lookup_pc = 32'h8000_0040;
        #1;
        n_cmp++; if (lookup_taken !== 1'b0) begin n_fail++; $display("FAIL bht_initial: got %0b want 0", lookup_taken); end
        for (int k = 0; k < 6; k++) begin
            // four taken beq, then two not-taken bne
            do_req(k < 4 ? 3'd4 : 3'd5, 1'b0, 32'h8000_0040, 32'd9, 32'd9, 32'h8, 1'b0, 32'h0);
            lookup_pc = 32'h8000_0040;
            #1;
            n_cmp++;
            if (lookup_taken !== want[k] || lookup_taken !== (m_bht[16] >= 2))
                begin n_fail++; $display("FAIL bht_step%0d: got %0b want %0b", k, lookup_taken, want[k]); end
        end
    endtask

    task automatic test_stall();
        logic        h_taken, h_mis;
        logic [31:0] h_npc, h_link;
        do_req(3'd4, 1'b0, 32'h8000_0100, 32'd1, 32'd1, 32'h30, 1'b1, 32'h8000_0130);
        h_taken = exp_taken; h_npc = exp_npc; h_link = exp_link; h_mis = exp_mis;
        out_ready = 1'b0;
        in_valid = 1'b1; in_branch = 3'd4; in_unsigned = 1'b0; in_pc = 32'h8000_0040;
        in_rs1 = 32'd3; in_rs2 = 32'd3; in_imm = 32'h100; in_pred_taken = 1'b0;
        lookup_pc = 32'h8000_0040;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c%0d: got %0b want 0", c, in_ready); end
            n_cmp++;
            if (out_valid !== 1'b1 || out_taken !== h_taken || out_next_pc !== h_npc ||
                out_link !== h_link || out_mispredict !== h_mis) begin
                n_fail++;
                $display("FAIL stall_hold c%0d: got v%0b t%0b pc %h link %h m%0b want v1 t%0b pc %h link %h m%0b",
                         c, out_valid, out_taken, out_next_pc, out_link, out_mispredict, h_taken, h_npc, h_link, h_mis);
            end
            n_cmp++;
            if (perf_branches !== 32'(m_br) || perf_mispredicts !== 32'(m_mis)) begin
                n_fail++; $display("FAIL stall_perf c%0d: got %0d/%0d want %0d/%0d", c, perf_branches, perf_mispredicts, m_br, m_mis);
            end
            n_cmp++; if (lookup_taken !== (m_bht[16] >= 2)) begin n_fail++; $display("FAIL stall_bht c%0d: got %0b want %0b", c, lookup_taken, m_bht[16] >= 2); end
        end
        out_ready = 1'b1;
        #1;
        // Lookup at the index being trained this very cycle must still show the old counter.
        n_cmp++; if (lookup_taken !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got %0b want 0", lookup_taken); end
        do_req(3'd4, 1'b0, 32'h8000_0040, 32'd3, 32'd3, 32'h100, 1'b0, 32'h0);
        n_cmp++; if (out_valid !== 1'b1 || out_next_pc !== exp_npc) begin n_fail++; $display("FAIL release_first: got v%0b pc %h want v1 pc %h", out_valid, out_next_pc, exp_npc); end
        do_req(3'd1, 1'b0, 32'h8000_0500, 32'd0, 32'd0, 32'hFFFF_FF00, 1'b0, 32'h0);
        n_cmp++; if (out_valid !== 1'b1 || out_next_pc !== exp_npc) begin n_fail++; $display("FAIL back_to_back: got v%0b pc %h want v1 pc %h", out_valid, out_next_pc, exp_npc); end
        n_cmp++;
        if (perf_branches !== 32'(m_br) || perf_mispredicts !== 32'(m_mis)) begin
            n_fail++; $display("FAIL release_perf: got %0d/%0d want %0d/%0d", perf_branches, perf_mispredicts, m_br, m_mis);
        end
        n_cmp++; if (lookup_taken !== 1'b1) begin n_fail++; $display("FAIL release_bht: got %0b want 1", lookup_taken); end
    endtask

    task automatic test_random();
        logic [2:0]  br;
        logic        uns, pt;
        logic [31:0] pc, rs1, rs2, imm, ptgt, lpc;
        for (int n = 0; n < 300; n++) begin
            br  = 3'($urandom_range(0, 7));
            uns = 1'($urandom_range(0, 1));
            pc  = 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
            rs1 = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 3)) - 32'd2;
            rs2 = ($urandom_range(0, 2) == 0) ? rs1 : (($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 3)) - 32'd2);
            imm = $urandom();
            pt  = 1'($urandom_range(0, 1));
            ptgt = ($urandom_range(0, 1) == 1) ? pc + imm : $urandom();
            do_req(br, uns, pc, rs1, rs2, imm, pt, ptgt);
            n_cmp++;
            if (out_valid !== 1'b1 || out_taken !== exp_taken || out_next_pc !== exp_npc ||
                out_link !== exp_link || out_mispredict !== exp_mis) begin
                n_fail++;
                $display("FAIL rand%0d br=%0d: got v%0b t%0b pc %h link %h m%0b want v1 t%0b pc %h link %h m%0b",
                         n, br, out_valid, out_taken, out_next_pc, out_link, out_mispredict, exp_taken, exp_npc, exp_link, exp_mis);
            end
            n_cmp++;
            if (perf_branches !== 32'(m_br) || perf_mispredicts !== 32'(m_mis)) begin
                n_fail++; $display("FAIL rand_perf%0d: got %0d/%0d want %0d/%0d", n, perf_branches, perf_mispredicts, m_br, m_mis);
            end
            lpc = 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
            lookup_pc = lpc;
            #1;
            n_cmp++;
            if (lookup_taken !== (m_bht[idx_of(lpc)] >= 2)) begin
                n_fail++; $display("FAIL rand_bht%0d idx %0d: got %0b want %0b", n, idx_of(lpc), lookup_taken, m_bht[idx_of(lpc)] >= 2);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_req(3'd5, 1'b0, 32'h8000_0080, 32'd1, 32'd2, 32'h40, 1'b0, 32'h0);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_next_pc !== 32'h0 || out_link !== 32'h0 || out_taken !== 1'b0 || out_mispredict !== 1'b0)
            begin n_fail++; $display("FAIL midrst_outs: got pc %h link %h t%0b m%0b want zeros", out_next_pc, out_link, out_taken, out_mispredict); end
        n_cmp++; if (perf_branches !== 32'h0 || perf_mispredicts !== 32'h0)
            begin n_fail++; $display("FAIL midrst_perf: got %0d/%0d want 0/0", perf_branches, perf_mispredicts); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
        for (int i = 0; i < 64; i++) begin
            lookup_pc = 32'(i) << 2;
            #0.1;
            n_cmp++;
            if (lookup_taken !== 1'b0) begin n_fail++; $display("FAIL midrst_bht[%0d]: got %0b want 0", i, lookup_taken); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_beq();
        test_blt();
        test_jalr();
        test_bht();
        test_stall();
        test_random();
        test_mid_reset();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
